// File: rtl/picorv32_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module   : picorv32_bus_fabric
// Brief    : Bus fabric from the picorv32 native memory port to NSLAVES
//            address-decoded slaves. It provides a CPU reset sequencer, a
//            per-access timeout and sticky capture of error responses.
// Revision : 1.0 - initial release
// ============================================================================
module picorv32_bus_fabric #(
    parameter int          NSLAVES        = 4,
    parameter int          REGION_BITS    = 16,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          RESET_CYCLES   = 4,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  cpu_resetn,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_rdata,
    output logic [NSLAVES-1:0]    s_valid,
    input  logic [NSLAVES-1:0]    s_ready,
    output logic [31:0]           s_addr,
    output logic [31:0]           s_wdata,
    output logic [3:0]            s_wstrb,
    input  logic [32*NSLAVES-1:0] s_rdata,
    input  logic                  err_clear,
    output logic                  bus_err,
    output logic [31:0]           err_addr,
    output logic [7:0]            err_count
);

    localparam int          c_IDX_W    = $clog2(NSLAVES);
    localparam int          c_DEC_BITS = REGION_BITS + c_IDX_W;
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  c_RST_LAST = 8'(RESET_CYCLES - 1);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ACTIVE = 2'd1;
    localparam logic [1:0] c_S_RESP   = 2'd2;

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [15:0]        r_tmo;
    logic [7:0]         r_rst_cnt;
    logic               r_cpu_resetn;
    logic [31:0]        r_rdata;
    logic [31:0]        r_s_addr;
    logic [31:0]        r_s_wdata;
    logic [3:0]         r_s_wstrb;
    logic               r_bus_err;
    logic [31:0]        r_err_addr;
    logic [7:0]         r_err_count;

    logic [c_IDX_W-1:0] w_req_idx;
    logic               w_mapped;
    logic               w_accept;
    logic               w_sel_ready;
    logic [31:0]        w_sel_rdata;
    logic               w_unmapped_err;
    logic               w_timeout_err;
    logic               w_err;
    logic [31:0]        w_err_addr;
    logic [NSLAVES-1:0] w_onehot;

    // Decode the incoming request and select the active slave's response.
    always_comb begin
        w_req_idx      = mem_addr[REGION_BITS +: c_IDX_W];
        w_mapped       = ((mem_addr >> c_DEC_BITS) == 32'd0);
        w_accept       = (r_state == c_S_IDLE) && mem_valid && r_cpu_resetn;
        w_sel_ready    = s_ready[r_idx];
        w_sel_rdata    = s_rdata[32*r_idx +: 32];
        w_unmapped_err = w_accept && !w_mapped;
        // Ready in the final timeout cycle still completes normally.
        w_timeout_err  = (r_state == c_S_ACTIVE) && !w_sel_ready && (r_tmo == c_TMO_LAST);
        w_err          = w_unmapped_err || w_timeout_err;
        w_err_addr     = w_unmapped_err ? mem_addr : r_s_addr;
        w_onehot       = '0;
        if (r_state == c_S_ACTIVE) begin
            w_onehot[r_idx] = 1'b1;
        end
    end

    // Hold the CPU in reset for RESET_CYCLES edges after the fabric leaves reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_cnt    <= 8'd0;
            r_cpu_resetn <= 1'b0;
        end else if (!r_cpu_resetn) begin
            if (r_rst_cnt == c_RST_LAST) begin
                r_cpu_resetn <= 1'b1;
            end else begin
                r_rst_cnt <= r_rst_cnt + 8'd1;
            end
        end
    end

    // Access state machine: latch request, wait for slave or timeout, respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_idx     <= '0;
            r_tmo     <= 16'd0;
            r_rdata   <= 32'd0;
            r_s_addr  <= 32'd0;
            r_s_wdata <= 32'd0;
            r_s_wstrb <= 4'd0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_s_addr  <= mem_addr;
                        r_s_wdata <= mem_wdata;
                        r_s_wstrb <= mem_wstrb;
                        r_idx     <= w_req_idx;
                        r_tmo     <= 16'd0;
                        if (w_mapped) begin
                            r_state <= c_S_ACTIVE;
                        end else begin
                            r_rdata <= ERR_RDATA;
                            r_state <= c_S_RESP;
                        end
                    end
                end
                c_S_ACTIVE: begin
                    if (w_sel_ready) begin
                        r_rdata <= w_sel_rdata;
                        r_state <= c_S_RESP;
                    end else if (w_timeout_err) begin
                        r_rdata <= ERR_RDATA;
                        r_state <= c_S_RESP;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
                c_S_RESP: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Sticky error capture; a new error wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_err   <= 1'b0;
            r_err_addr  <= 32'd0;
            r_err_count <= 8'd0;
        end else if (w_err) begin
            r_bus_err  <= 1'b1;
            r_err_addr <= w_err_addr;
            if (err_clear) begin
                r_err_count <= 8'd1;
            end else if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end else if (err_clear) begin
            r_bus_err   <= 1'b0;
            r_err_count <= 8'd0;
        end
    end

    assign cpu_resetn = r_cpu_resetn;
    assign mem_ready  = (r_state == c_S_RESP);
    assign mem_rdata  = r_rdata;
    assign s_valid    = w_onehot;
    assign s_addr     = r_s_addr;
    assign s_wdata    = r_s_wdata;
    assign s_wstrb    = r_s_wstrb;
    assign bus_err    = r_bus_err;
    assign err_addr   = r_err_addr;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_picorv32_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module   : tb_picorv32_bus_fabric
// Brief    : Directed self-checking bench for picorv32_bus_fabric.
// Revision : 1.0 - initial release
// ============================================================================
module tb_picorv32_bus_fabric;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_resetn;
    logic         mem_valid;
    logic         mem_ready;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_wstrb;
    logic [31:0]  mem_rdata;
    logic [3:0]   s_valid;
    logic [3:0]   s_ready;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [127:0] s_rdata;
    logic         err_clear;
    logic         bus_err;
    logic [31:0]  err_addr;
    logic [7:0]   err_count;

    int checks   = 0;
    int failures = 0;

    picorv32_bus_fabric dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_resetn (cpu_resetn),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_rdata    (s_rdata),
        .err_clear  (err_clear),
        .bus_err    (bus_err),
        .err_addr   (err_addr),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        s_ready   = 4'd0;
        s_rdata   = {32'h33333333, 32'h22222222, 32'h12345678, 32'hAAAA5555};
        err_clear = 1'b0;
        tick();
        tick();
        chk("rst_cpu_resetn", {31'd0, cpu_resetn}, 32'd0);
        chk("rst_mem_ready",  {31'd0, mem_ready},  32'd0);
        chk("rst_s_valid",    {28'd0, s_valid},    32'd0);
        chk("rst_mem_rdata",  mem_rdata,           32'd0);
        chk("rst_s_addr",     s_addr,              32'd0);
        chk("rst_err",        {23'd0, bus_err, err_count}, 32'd0);
        chk("rst_err_addr",   err_addr,            32'd0);

        // Release reset with a request already pending; it must wait for cpu_resetn.
        rst       = 1'b0;
        mem_valid = 1'b1;
        mem_addr  = 32'h0001_0004;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("seq_cpu_resetn_low", {31'd0, cpu_resetn}, 32'd0);
            chk("seq_s_valid_idle",   {28'd0, s_valid},    32'd0);
        end
        tick();
        chk("seq_cpu_resetn_high", {31'd0, cpu_resetn}, 32'd1);
        chk("seq_s_valid_still",   {28'd0, s_valid},    32'd0);

        // Read slave 1, ready in the third s_valid cycle.
        tick();
        chk("rd_s_valid_1", {28'd0, s_valid}, 32'h2);
        chk("rd_s_addr",    s_addr,           32'h0001_0004);
        chk("rd_s_wstrb",   {28'd0, s_wstrb}, 32'h0);
        tick();
        chk("rd_s_valid_2", {28'd0, s_valid}, 32'h2);
        tick();
        chk("rd_s_valid_3", {28'd0, s_valid}, 32'h2);
        chk("rd_no_ready",  {31'd0, mem_ready}, 32'd0);
        s_ready = 4'b0010;
        tick();
        s_ready   = 4'b0000;
        mem_valid = 1'b0;
        chk("rd_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("rd_s_valid_0", {28'd0, s_valid},   32'h0);
        chk("rd_rdata",     mem_rdata,          32'h1234_5678);
        chk("rd_no_err",    {31'd0, bus_err},   32'd0);
        tick();
        chk("rd_ready_pulse", {31'd0, mem_ready}, 32'd0);
        chk("rd_rdata_hold",  mem_rdata,          32'h1234_5678);

        // Unmapped write: error response one cycle after the request.
        mem_valid = 1'b1;
        mem_addr  = 32'h8000_0000;
        mem_wdata = 32'hCAFE_F00D;
        mem_wstrb = 4'hF;
        tick();
        mem_valid = 1'b0;
        chk("wr_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("wr_s_valid",   {28'd0, s_valid},   32'h0);
        chk("wr_rdata",     mem_rdata,          32'hDEAD_BEEF);
        chk("wr_bus_err",   {31'd0, bus_err},   32'd1);
        chk("wr_err_addr",  err_addr,           32'h8000_0000);
        chk("wr_err_count", {24'd0, err_count}, 32'd1);
        chk("wr_s_wdata",   s_wdata,            32'hCAFE_F00D);
        tick();
        chk("wr_ready_pulse", {31'd0, mem_ready}, 32'd0);

        // First address beyond the decoded window is unmapped.
        mem_valid = 1'b1;
        mem_addr  = 32'h0004_0000;
        mem_wstrb = 4'h0;
        tick();
        mem_valid = 1'b0;
        chk("edge_s_valid",  {28'd0, s_valid},   32'h0);
        chk("edge_err_addr", err_addr,           32'h0004_0000);
        chk("edge_err_cnt",  {24'd0, err_count}, 32'd2);
        tick();

        // Slave 2 never answers: s_valid high 255 cycles, then error.
        mem_valid = 1'b1;
        mem_addr  = 32'h0002_0000;
        tick();
        for (int i = 0; i < 254; i++) begin
            chk("to_s_valid_hold", {28'd0, s_valid}, 32'h4);
            tick();
        end
        chk("to_s_valid_last", {28'd0, s_valid}, 32'h4);
        chk("to_not_ready",    {31'd0, mem_ready}, 32'd0);
        tick();
        mem_valid = 1'b0;
        chk("to_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("to_s_valid_0", {28'd0, s_valid},   32'h0);
        chk("to_rdata",     mem_rdata,          32'hDEAD_BEEF);
        chk("to_err_addr",  err_addr,           32'h0002_0000);
        chk("to_err_cnt",   {24'd0, err_count}, 32'd3);
        tick();

        // Saturate the error counter with unmapped accesses.
        for (int i = 0; i < 300; i++) begin
            mem_valid = 1'b1;
            mem_addr  = 32'h8000_0000 | (i << 2);
            tick();
            mem_valid = 1'b0;
            tick();
        end
        chk("sat_err_cnt", {24'd0, err_count}, 32'd255);
        chk("sat_bus_err", {31'd0, bus_err},   32'd1);

        // Clear, then clear coinciding with a new error.
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("clr_err_cnt", {24'd0, err_count}, 32'd0);
        chk("clr_bus_err", {31'd0, bus_err},   32'd0);
        err_clear = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = 32'hF000_0010;
        tick();
        err_clear = 1'b0;
        mem_valid = 1'b0;
        chk("clrerr_bus_err", {31'd0, bus_err},   32'd1);
        chk("clrerr_err_cnt", {24'd0, err_count}, 32'd1);
        chk("clrerr_addr",    err_addr,           32'hF000_0010);
        tick();

        // Slave 3 selected, slave 0 ready must be ignored -> timeout.
        mem_valid = 1'b1;
        mem_addr  = 32'h0003_0010;
        tick();
        s_ready = 4'b0001;
        chk("ign_s_valid", {28'd0, s_valid}, 32'h8);
        repeat (254) tick();
        chk("ign_s_valid_last", {28'd0, s_valid}, 32'h8);
        tick();
        s_ready   = 4'b0000;
        mem_valid = 1'b0;
        chk("ign_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("ign_rdata",     mem_rdata,          32'hDEAD_BEEF);
        chk("ign_err_cnt",   {24'd0, err_count}, 32'd2);
        chk("ign_err_addr",  err_addr,           32'h0003_0010);
        tick();

        // Ready arriving in the last timeout cycle wins: no error.
        mem_valid = 1'b1;
        mem_addr  = 32'h0001_0020;
        tick();
        repeat (254) tick();
        s_ready = 4'b0010;
        tick();
        s_ready   = 4'b0000;
        mem_valid = 1'b0;
        chk("race_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("race_rdata",     mem_rdata,          32'h1234_5678);
        chk("race_err_cnt",   {24'd0, err_count}, 32'd2);
        tick();

        // Reset in the middle of an access drops outputs immediately.
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0008;
        tick();
        chk("mid_s_valid", {28'd0, s_valid}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_s_valid",    {28'd0, s_valid},    32'h0);
        chk("mid_rst_cpu_resetn", {31'd0, cpu_resetn}, 32'd0);
        chk("mid_rst_mem_ready",  {31'd0, mem_ready},  32'd0);
        chk("mid_rst_err_cnt",    {24'd0, err_count},  32'd0);
        mem_valid = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("rec_cpu_resetn_low", {31'd0, cpu_resetn}, 32'd0);
        tick();
        chk("rec_cpu_resetn", {31'd0, cpu_resetn}, 32'd1);

        // Zero-wait read from slave 0 after recovery: mem_ready at N+2.
        mem_valid = 1'b1;
        s_ready   = 4'b0001;
        tick();
        chk("zw_s_valid", {28'd0, s_valid}, 32'h1);
        chk("zw_wait",    {31'd0, mem_ready}, 32'd0);
        tick();
        mem_valid = 1'b0;
        s_ready   = 4'b0000;
        chk("zw_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("zw_rdata",     mem_rdata,          32'hAAAA_5555);
        chk("zw_no_err",    {31'd0, bus_err},   32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
